// File: rtl/sram_page_allocator.sv
// rtl/sram_page_allocator.sv - free-list allocator for shared packet cache SRAM pages
//
// Ports:
//   clk           system clock
//   rst           synchronous active-high reset; rebuilds the free list from scratch
//   alloc_req     pop request, honoured only while alloc_vld=1
//   alloc_vld     a free page is available and the list is initialised
//   alloc_addr    free page at list head (valid while alloc_vld=1)
//   free0_en/addr page return, channel 0 (read1), priority over channel 1
//   free1_en/addr page return, channel 1 (read2)
//   init_done     free list fully populated after reset
//   free_count    number of free pages, 0..num_pages
//   almost_empty  free_count <= almost_empty_th
//   err_overflow  sticky: a return was dropped because the list was full
module sram_page_allocator #(
    parameter int page_addr_width = 8,
    parameter int almost_empty_th = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       alloc_req,
    output logic                       alloc_vld,
    output logic [page_addr_width-1:0] alloc_addr,
    input  logic                       free0_en,
    input  logic [page_addr_width-1:0] free0_addr,
    input  logic                       free1_en,
    input  logic [page_addr_width-1:0] free1_addr,
    output logic                       init_done,
    output logic [page_addr_width:0]   free_count,
    output logic                       almost_empty,
    output logic                       err_overflow
);
    localparam int aw        = page_addr_width;
    localparam int cw        = page_addr_width + 1;
    localparam int rw        = page_addr_width + 2;
    localparam int num_pages = 2 ** page_addr_width;

    typedef enum logic {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } state_t;

    state_t         state_q, state_d;
    logic [aw-1:0]  init_idx_q, init_idx_d;
    logic [aw-1:0]  rd_ptr_q, rd_ptr_d;
    logic [aw-1:0]  wr_ptr_q, wr_ptr_d;
    logic [cw-1:0]  count_q, count_d;
    logic           almost_empty_q;
    logic           err_overflow_q, err_overflow_d;

    logic [aw-1:0]  mem [num_pages];

    logic           pop;
    logic           acc0;
    logic           acc1;
    logic           drop;
    logic [rw-1:0]  room;
    logic           we_a, we_b;
    logic [aw-1:0]  waddr_a, wdata_a, waddr_b, wdata_b;

    assign alloc_vld    = (state_q == ST_READY) && (count_q != '0);
    assign alloc_addr   = mem[rd_ptr_q];
    assign init_done    = (state_q == ST_READY);
    assign free_count   = count_q;
    assign almost_empty = almost_empty_q;
    assign err_overflow = err_overflow_q;

    always_comb begin
        state_d        = state_q;
        init_idx_d     = init_idx_q;
        rd_ptr_d       = rd_ptr_q;
        wr_ptr_d       = wr_ptr_q;
        count_d        = count_q;
        err_overflow_d = err_overflow_q;
        pop            = 1'b0;
        acc0           = 1'b0;
        acc1           = 1'b0;
        drop           = 1'b0;
        room           = '0;
        we_a           = 1'b0;
        waddr_a        = wr_ptr_q;
        wdata_a        = free0_addr;
        we_b           = 1'b0;
        waddr_b        = wr_ptr_q;
        wdata_b        = free1_addr;

        if (state_q == ST_INIT) begin
            // Seed the list with every page in order; wr_ptr stays 0, which is
            // exactly where it would land after num_pages wrapping increments.
            we_a       = 1'b1;
            waddr_a    = init_idx_q;
            wdata_a    = init_idx_q;
            init_idx_d = init_idx_q + aw'(1);
            count_d    = count_q + cw'(1);
            if (init_idx_q == aw'(num_pages - 1)) begin
                state_d = ST_READY;
            end
        end else begin
            pop  = alloc_req && alloc_vld;
            // Slots available this cycle, counting the slot a pop frees up.
            room = rw'(num_pages) - rw'(count_q) + rw'(pop);
            acc0 = free0_en && (room != '0);
            acc1 = free1_en && (room > rw'(acc0));
            drop = (free0_en && !acc0) || (free1_en && !acc1);

            we_a    = acc0;
            we_b    = acc1;
            // Channel 1 lands behind channel 0 when both are accepted.
            waddr_b = wr_ptr_q + aw'(acc0);

            rd_ptr_d       = rd_ptr_q + aw'(pop);
            wr_ptr_d       = wr_ptr_q + aw'(acc0) + aw'(acc1);
            count_d        = count_q - cw'(pop) + cw'(acc0) + cw'(acc1);
            err_overflow_d = err_overflow_q || drop;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_INIT;
            init_idx_q     <= '0;
            rd_ptr_q       <= '0;
            wr_ptr_q       <= '0;
            count_q        <= '0;
            almost_empty_q <= 1'b1;
            err_overflow_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            init_idx_q     <= init_idx_d;
            rd_ptr_q       <= rd_ptr_d;
            wr_ptr_q       <= wr_ptr_d;
            count_q        <= count_d;
            almost_empty_q <= (count_d <= cw'(almost_empty_th));
            err_overflow_q <= err_overflow_d;
        end
    end

    // List storage carries no reset; INIT rewrites every entry.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (we_a) begin
                mem[waddr_a] <= wdata_a;
            end
            if (we_b) begin
                mem[waddr_b] <= wdata_b;
            end
        end
    end

endmodule

// File: tb/tb_sram_page_allocator.sv
// tb/tb_sram_page_allocator.sv - randomized self-checking bench for sram_page_allocator
module tb_sram_page_allocator;
    localparam int aw = 8;
    localparam int np = 256;
    localparam int th = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          alloc_req = 1'b0;
    logic          alloc_vld;
    logic [aw-1:0] alloc_addr;
    logic          free0_en = 1'b0;
    logic [aw-1:0] free0_addr = '0;
    logic          free1_en = 1'b0;
    logic [aw-1:0] free1_addr = '0;
    logic          init_done;
    logic [aw:0]   free_count;
    logic          almost_empty;
    logic          err_overflow;

    sram_page_allocator #(
        .page_addr_width(aw),
        .almost_empty_th(th)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .alloc_req   (alloc_req),
        .alloc_vld   (alloc_vld),
        .alloc_addr  (alloc_addr),
        .free0_en    (free0_en),
        .free0_addr  (free0_addr),
        .free1_en    (free1_en),
        .free1_addr  (free1_addr),
        .init_done   (init_done),
        .free_count  (free_count),
        .almost_empty(almost_empty),
        .err_overflow(err_overflow)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [aw-1:0] mq[$];
    bit            m_ready = 1'b0;
    int            m_init  = 0;
    bit            m_err   = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic void model_update();
        if (rst) begin
            mq.delete();
            m_ready = 1'b0;
            m_init  = 0;
            m_err   = 1'b0;
        end else if (!m_ready) begin
            mq.push_back(aw'(m_init));
            m_init++;
            if (m_init == np) m_ready = 1'b1;
        end else begin
            if (alloc_req && mq.size() != 0) void'(mq.pop_front());
            if (free0_en) begin
                if (mq.size() < np) mq.push_back(free0_addr);
                else m_err = 1'b1;
            end
            if (free1_en) begin
                if (mq.size() < np) mq.push_back(free1_addr);
                else m_err = 1'b1;
            end
        end
    endfunction

    task automatic check_outputs();
        check_eq("init_done", init_done, m_ready);
        check_eq("alloc_vld", alloc_vld, m_ready && mq.size() != 0);
        check_eq("free_count", free_count, mq.size());
        check_eq("almost_empty", almost_empty, mq.size() <= th);
        check_eq("err_overflow", err_overflow, m_err);
        if (m_ready && mq.size() != 0) check_eq("alloc_addr", alloc_addr, mq[0]);
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
        check_outputs();
    endtask

    task automatic idle();
        alloc_req = 1'b0;
        free0_en  = 1'b0;
        free1_en  = 1'b0;
    endtask

    task automatic reset_and_init();
        idle();
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < np; i++) step();
        check_eq("init_done_after_init", init_done, 1);
        check_eq("init_head", alloc_addr, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;

        // Reset state and exact init length.
        idle();
        rst = 1'b1;
        step();
        step();
        check_eq("rst_count", free_count, 0);
        check_eq("rst_vld", alloc_vld, 0);
        check_eq("rst_ae", almost_empty, 1);
        rst = 1'b0;
        for (int i = 0; i < np - 1; i++) step();
        check_eq("init_not_yet", init_done, 0);
        step();
        check_eq("init_at_256", init_done, 1);
        check_eq("init_count", free_count, 256);
        check_eq("init_vld", alloc_vld, 1);
        check_eq("init_head", alloc_addr, 0);
        check_eq("init_ae", almost_empty, 0);

        // Three back-to-back allocations.
        alloc_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check_eq("alloc_seq", alloc_addr, i);
            step();
        end
        alloc_req = 1'b0;
        check_eq("alloc3_count", free_count, 253);

        // Drain everything, then over-request.
        alloc_req = 1'b1;
        for (n = 0; n < 300 && mq.size() != 0; n++) step();
        check_eq("drain_empty", free_count, 0);
        for (int i = 0; i < 3; i++) step();
        check_eq("empty_vld", alloc_vld, 0);
        check_eq("empty_ae", almost_empty, 1);
        alloc_req  = 1'b0;
        free0_en   = 1'b1;
        free0_addr = 8'h37;
        step();
        idle();
        check_eq("refill_vld", alloc_vld, 1);
        check_eq("refill_addr", alloc_addr, 8'h37);
        check_eq("refill_count", free_count, 1);

        // Simultaneous pop and dual return at count 100.
        free0_en = 1'b1;
        for (n = 0; n < 200 && mq.size() < 100; n++) begin
            free0_addr = aw'($urandom);
            step();
        end
        idle();
        check_eq("fill_100", free_count, 100);
        alloc_req  = 1'b1;
        free0_en   = 1'b1;
        free0_addr = 8'h05;
        free1_en   = 1'b1;
        free1_addr = 8'h09;
        step();
        idle();
        check_eq("dual_count", free_count, 101);
        alloc_req = 1'b1;
        for (n = 0; n < 200 && mq.size() != 0; n++) begin
            if (mq.size() == 2) check_eq("tail_first", alloc_addr, 8'h05);
            if (mq.size() == 1) check_eq("tail_second", alloc_addr, 8'h09);
            step();
        end
        idle();
        check_eq("tail_drained", free_count, 0);

        // Overflow at full, then at 255.
        reset_and_init();
        free0_en   = 1'b1;
        free0_addr = 8'hAA;
        free1_en   = 1'b1;
        free1_addr = 8'hBB;
        step();
        idle();
        check_eq("ovf_full_count", free_count, 256);
        check_eq("ovf_full_err", err_overflow, 1);
        for (int i = 0; i < 4; i++) step();
        check_eq("ovf_sticky", err_overflow, 1);
        alloc_req = 1'b1;
        step();
        idle();
        check_eq("ovf_255", free_count, 255);
        free0_en   = 1'b1;
        free0_addr = 8'h11;
        free1_en   = 1'b1;
        free1_addr = 8'h22;
        step();
        idle();
        check_eq("ovf_partial_count", free_count, 256);
        check_eq("ovf_partial_err", err_overflow, 1);

        // Randomized traffic against the model.
        reset_and_init();
        for (int i = 0; i < 2500; i++) begin
            int bias;
            bias       = (i / 500) % 2;
            alloc_req  = ($urandom_range(0, 9) < (bias ? 7 : 3));
            free0_en   = ($urandom_range(0, 9) < (bias ? 3 : 5));
            free0_addr = aw'($urandom);
            free1_en   = ($urandom_range(0, 9) < (bias ? 2 : 4));
            free1_addr = aw'($urandom);
            step();
        end

        // Mid-traffic reset at count 40.
        idle();
        for (n = 0; n < 600 && mq.size() != 40; n++) begin
            alloc_req  = (mq.size() > 40);
            free0_en   = (mq.size() < 40);
            free0_addr = aw'($urandom);
            step();
        end
        check_eq("reach_40", free_count, 40);
        alloc_req  = 1'b1;
        free0_en   = 1'b1;
        free1_en   = 1'b1;
        rst        = 1'b1;
        step();
        rst = 1'b0;
        idle();
        check_eq("midrst_count", free_count, 0);
        check_eq("midrst_vld", alloc_vld, 0);
        for (int i = 0; i < np; i++) step();
        check_eq("reinit_done", init_done, 1);
        check_eq("reinit_head", alloc_addr, 0);
        check_eq("reinit_count", free_count, 256);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
